snake_engine: RTL

Parametrised snake body engine. Holds up to MAX_LEN segment coordinates in grid units and advances the snake one cell per `step` strobe. After each move it runs a multi-cycle self-collision scan. It also answers a one-cycle-latency pixel/cell query for the VGA renderer. It sits between the keyboard direction decoder / update tick and the renderer, and replaces the fixed 128-entry, 10-pixel-step logic with a configurable grid engine that has an explicit game FSM.

---
 rtl/snake_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/snake_engine.sv
// Grid-based snake body engine: segment shift register, move/self-collision FSM and
// a registered one-cycle cell query. Define SNAKE_WRAP_EN to make the walls wrap around.
module snake_engine #(
    parameter int MAX_LEN   = 64,
    parameter int XW        = 6,
    parameter int YW        = 6,
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int START_X   = 32,
    parameter int START_Y   = 24,
    parameter int START_LEN = 3
) (
    input  logic                           master_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           step,
    input  logic [1:0]                     dir_in,
    input  logic                           grow,
    input  logic [XW-1:0]                  q_x,
    input  logic [YW-1:0]                  q_y,
    output logic                           q_head,
    output logic                           q_body,
    output logic [XW-1:0]                  head_x,
    output logic [YW-1:0]                  head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic                           busy,
    output logic                           step_done,
    output logic                           dead
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DEAD} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   seg_x_q [MAX_LEN];
    logic [XW-1:0]   seg_x_d [MAX_LEN];
    logic [YW-1:0]   seg_y_q [MAX_LEN];
    logic [YW-1:0]   seg_y_d [MAX_LEN];
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [1:0]      dir_q, dir_d;
    logic            grow_q, grow_d;
    logic            done_q, done_d;
    logic            q_head_q, q_head_d;
    logic            q_body_q, q_body_d;

    logic [1:0]      new_dir_s;
    logic [XW:0]     nx_s;
    logic [YW:0]     ny_s;
    logic            wall_s;
    logic            hit_s;

    // Next head position; one extra bit so stepping below zero shows up as out of range.
    always_comb begin
        new_dir_s = ((dir_in ^ dir_q) == 2'b10) ? dir_q : dir_in;
        nx_s = {1'b0, seg_x_q[0]};
        ny_s = {1'b0, seg_y_q[0]};
        case (new_dir_s)
            2'b00: ny_s = (WRAP && seg_y_q[0] == YW'(0)) ? (YW+1)'(GRID_H - 1) : ny_s - (YW+1)'(1);
            2'b01: nx_s = (WRAP && seg_x_q[0] == XW'(0)) ? (XW+1)'(GRID_W - 1) : nx_s - (XW+1)'(1);
            2'b10: ny_s = (WRAP && seg_y_q[0] == YW'(GRID_H - 1)) ? (YW+1)'(0) : ny_s + (YW+1)'(1);
            default: nx_s = (WRAP && seg_x_q[0] == XW'(GRID_W - 1)) ? (XW+1)'(0) : nx_s + (XW+1)'(1);
        endcase
        wall_s = (nx_s >= (XW+1)'(GRID_W)) || (ny_s >= (YW+1)'(GRID_H));
        hit_s  = (seg_x_q[idx_q[IW-1:0]] == seg_x_q[0]) && (seg_y_q[idx_q[IW-1:0]] == seg_y_q[0]);
    end

    // Game FSM next-state: init on start, move on step, then scan body one index per cycle.
    always_comb begin
        state_d = state_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        grow_d  = grow_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = S_RUN;
            len_d   = LW'(START_LEN);
            idx_d   = LW'(1);
            dir_d   = 2'b11;
            grow_d  = 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN) begin
                    seg_x_d[i] = XW'(START_X - i);
                    seg_y_d[i] = YW'(START_Y);
                end else begin
                    seg_x_d[i] = seg_x_q[i];
                    seg_y_d[i] = seg_y_q[i];
                end
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (step && wall_s) begin
                        state_d = S_DEAD;
                    end else if (step) begin
                        dir_d = new_dir_s;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nx_s[XW-1:0];
                        seg_y_d[0] = ny_s[YW-1:0];
                        if (grow_q && (len_q < LW'(MAX_LEN))) begin
                            len_d = len_q + LW'(1);
                        end else begin
                            len_d = len_q;
                        end
                        // A grow arriving with this step belongs to the following move.
                        grow_d  = grow;
                        idx_d   = LW'(1);
                        state_d = S_SCAN;
                    end else begin
                        grow_d = grow_q | grow;
                    end
                end
                S_SCAN: begin
                    grow_d = grow_q | grow;
                    if (idx_q >= len_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else if (hit_s) begin
                        state_d = S_DEAD;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Parallel cell query against the segment state present at this edge.
    always_comb begin
        q_head_d = 1'b0;
        q_body_d = 1'b0;
        if (state_q != S_IDLE) begin
            q_head_d = (q_x == seg_x_q[0]) && (q_y == seg_y_q[0]);
            for (int i = 1; i < MAX_LEN; i++) begin
                q_body_d = q_body_d | ((LW'(i) < len_q) && (q_x == seg_x_q[i]) && (q_y == seg_y_q[i]));
            end
        end else begin
            q_head_d = 1'b0;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= XW'(0);
                seg_y_q[i] <= YW'(0);
            end
            len_q    <= LW'(0);
            idx_q    <= LW'(0);
            dir_q    <= 2'b11;
            grow_q   <= 1'b0;
            done_q   <= 1'b0;
            q_head_q <= 1'b0;
            q_body_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            grow_q   <= grow_d;
            done_q   <= done_d;
            q_head_q <= q_head_d;
            q_body_q <= q_body_d;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign busy      = (state_q == S_SCAN);
    assign dead      = (state_q == S_DEAD);
    assign step_done = done_q;
    assign q_head    = q_head_q;
    assign q_body    = q_body_q;

endmodule
